// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_feeder_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STREAM,
    WAIT_DONE,
    RELEASE
  } feeder_state_t;

  // Number of cycles needed to push a SIZE x SIZE tile through a diagonal skew.
  function automatic int unsigned skew_len(input int unsigned size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Row-load bus into the feeder's tile buffers.
interface systolic_feeder_if #(
  parameter int SIZE = 8
) ();

  logic                                       ld_valid;
  logic                                       ld_ready;
  logic                                       ld_mat;
  logic [SIZE*systolic_feeder_pkg::DATA_W-1:0] ld_data;

  modport master (
    output ld_valid,
    output ld_mat,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_mat,
    input  ld_data,
    output ld_ready
  );

endinterface

// File: rtl/systolic_feeder_tile_buffer.sv
// SIZE x SIZE int8 register file: one row-write port, whole tile readable combinationally.
module systolic_feeder_tile_buffer
  import systolic_feeder_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic                                    clock,
  input  logic                                    wr_en,
  input  logic [$clog2(SIZE)-1:0]                 wr_row,
  input  logic [SIZE-1:0][DATA_W-1:0]             wr_data,
  output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]   rd_mat
);

  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] mem;

  // Row write; contents are don't-care after reset so no reset term.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign rd_mat = mem;

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one A (weight) and one B (activation) tile and streams them diagonally
// skewed into a systolic array, sequencing the array's start/done handshake.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  systolic_feeder_if.slave              ld,
  input  logic                          run_req,
  input  logic                          run_acc,
  output logic                          run_err,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          sa_start,
  output logic                          sa_accumulate,
  input  logic                          sa_done,
  output logic [SIZE-1:0][DATA_W-1:0]   weight_out,
  output logic [SIZE-1:0][DATA_W-1:0]   act_out
);

  localparam int IW = $clog2(SIZE);
  localparam int SW = $clog2(2 * SIZE);
  localparam logic [IW-1:0] LAST_ROW  = IW'(SIZE - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(skew_len(SIZE) - 1);

  feeder_state_t state;
  logic [1:0]    full;
  logic [IW-1:0] cnt_a;
  logic [IW-1:0] cnt_b;
  logic          arm_cnt;
  logic [SW-1:0] step;

  logic accept;
  logic wr_en_a;
  logic wr_en_b;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_mat;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_mat;

  logic [SW-1:0]                 sel;
  logic [SW:0]                   diff;
  logic [SIZE-1:0][DATA_W-1:0]   sk_w;
  logic [SIZE-1:0][DATA_W-1:0]   sk_a;

  assign ld.ld_ready = (state == IDLE) && !full[ld.ld_mat];
  assign accept      = ld.ld_valid && ld.ld_ready;
  assign wr_en_a     = accept && !ld.ld_mat;
  assign wr_en_b     = accept &&  ld.ld_mat;

  systolic_feeder_tile_buffer #(.SIZE(SIZE)) u_buf_a (
    .clock   (clock),
    .wr_en   (wr_en_a),
    .wr_row  (cnt_a),
    .wr_data (ld.ld_data),
    .rd_mat  (a_mat)
  );

  systolic_feeder_tile_buffer #(.SIZE(SIZE)) u_buf_b (
    .clock   (clock),
    .wr_en   (wr_en_b),
    .wr_row  (cnt_b),
    .wr_data (ld.ld_data),
    .rd_mat  (b_mat)
  );

  // Lane data for the step about to be registered: step 0 while leaving ARM,
  // otherwise the step after the one currently on the outputs. Lane r of both
  // streams uses index sel - r, which is why one difference serves A and B.
  always_comb begin
    sel  = (state == ARM) ? '0 : step + SW'(1);
    sk_w = '0;
    sk_a = '0;
    diff = '0;
    for (int unsigned r = 0; r < SIZE; r++) begin
      diff = {1'b0, sel} - (SW + 1)'(r);
      if (!diff[SW] && (diff < (SW + 1)'(SIZE))) begin
        sk_w[r] = a_mat[r][diff[IW-1:0]];
        sk_a[r] = b_mat[diff[IW-1:0]][r];
      end
    end
  end

  // Load bookkeeping, run sequencing and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      full          <= '0;
      cnt_a         <= '0;
      cnt_b         <= '0;
      arm_cnt       <= 1'b0;
      step          <= '0;
      run_err       <= 1'b0;
      busy          <= 1'b0;
      tile_done     <= 1'b0;
      sa_start      <= 1'b0;
      sa_accumulate <= 1'b0;
      weight_out    <= '0;
      act_out       <= '0;
    end else begin
      run_err <= 1'b0;

      if (wr_en_a) begin
        if (cnt_a == LAST_ROW) begin
          cnt_a   <= '0;
          full[0] <= 1'b1;
        end else begin
          cnt_a <= cnt_a + IW'(1);
        end
      end
      if (wr_en_b) begin
        if (cnt_b == LAST_ROW) begin
          cnt_b   <= '0;
          full[1] <= 1'b1;
        end else begin
          cnt_b <= cnt_b + IW'(1);
        end
      end

      // Uses the pre-beat full flags, so a run_req alongside the completing beat is rejected.
      if (run_req && !((state == IDLE) && (&full))) begin
        run_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (run_req && (&full)) begin
            state         <= ARM;
            arm_cnt       <= 1'b0;
            busy          <= 1'b1;
            sa_start      <= 1'b1;
            sa_accumulate <= run_acc;
          end
        end
        ARM: begin
          if (arm_cnt) begin
            state      <= STREAM;
            step       <= '0;
            weight_out <= sk_w;
            act_out    <= sk_a;
          end else begin
            arm_cnt <= 1'b1;
          end
        end
        STREAM: begin
          if (step == LAST_STEP) begin
            state      <= WAIT_DONE;
            weight_out <= '0;
            act_out    <= '0;
          end else begin
            step       <= step + SW'(1);
            weight_out <= sk_w;
            act_out    <= sk_a;
          end
        end
        WAIT_DONE: begin
          if (sa_done) begin
            state     <= RELEASE;
            sa_start  <= 1'b0;
            tile_done <= 1'b1;
          end
        end
        RELEASE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          tile_done     <= 1'b0;
          sa_accumulate <= 1'b0;
          full          <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
